sw_release_led_ctrl: RTL
========================

Name: sw_release_led_ctrl

Overview:
- Downstream consumer of the debounced switch level. Drives the board LED from clean switch activity.
- A short press that is then released toggles the steady LED state.
- A long press that is then released toggles between STEADY and BLINK display modes.
- Sits between the switch debouncer output and the LED pin. Single clock domain; the input is already synchronous to clk.

Parameters:
- LONG_LIMIT, 25000000, count of high samples that qualifies a long press (1 s at 25 MHz); legal range >= 2.
- BLINK_HALF, 6250000, cycles per blink half-period (250 ms at 25 MHz); legal range >= 1.

Ports:
- clk  input  1  system clock (25 MHz)
- rst_n  input  1  asynchronous active-low reset
- sw_db  input  1  debounced switch level; 1 = pressed
- led  output  1  LED drive; 1 = on
- release_pulse  output  1  one-cycle pulse on every switch release
- long_press  output  1  one-cycle pulse when a held press reaches LONG_LIMIT
- blink_mode  output  1  1 while in BLINK mode

Behaviour:
- Reset (rst_n low, asynchronous): sw_d=0, press_cnt=0, fsm=IDLE, mode=STEADY, led_state=0, blink_phase=0, blink_cnt=0. All outputs are 0 and stay 0 until the first clk edge after rst_n deasserts. Asserting reset mid-press or mid-blink aborts everything; no toggle is produced.
- All state is registered; outputs are driven from registers or from decodes of registers only.
- sw_d holds sw_db sampled at the previous edge.
  - press_start = sw_db & ~sw_d.
  - release = ~sw_db & sw_d.
- If sw_db is already 1 when reset is released, the first edge counts as press_start.
- press_cnt width = clog2(LONG_LIMIT+1).
  - Loaded with 1 on press_start; increments on each edge with sw_db sampled 1.
  - Saturates at LONG_LIMIT and never wraps.
- FSM states: IDLE, PRESSED, LONG_HELD.
  - IDLE -> PRESSED on press_start.
  - PRESSED -> LONG_HELD on the edge where press_cnt becomes LONG_LIMIT. long_press=1 for exactly that one cycle.
  - PRESSED -> IDLE on release (short release).
  - LONG_HELD -> IDLE on release (long release).
  - A press sampled high on LONG_LIMIT-1 edges is short; one sampled high on LONG_LIMIT edges is long.
- Release actions, registered at the release edge and visible after it; release_pulse=1 for exactly that cycle:
  - Short release, mode STEADY: led_state toggles.
  - Short release, mode BLINK: mode becomes STEADY; led_state is unchanged.
  - Long release, mode STEADY: mode becomes BLINK, blink_phase = ~led_state, blink_cnt=0.
  - Long release, mode BLINK: mode becomes STEADY; led_state is unchanged.
- Blink timing:
  - In BLINK, blink_cnt increments every cycle.
  - When blink_cnt = BLINK_HALF-1: blink_cnt returns to 0 and blink_phase toggles.
  - In STEADY, blink_cnt is held at 0.
- Output decode:
  - led = blink_mode ? blink_phase : led_state.
  - blink_mode = (mode == BLINK).
- Blinking continues while a new press is held. Mode changes only on release, never on press or on reaching LONG_LIMIT.
- Minimum release-to-press spacing is 1 cycle: a release and the next press_start on consecutive edges are both processed.
- Latency: an sw_db falling edge that precedes edge N (sw_db sampled 1 at edge N-1) produces the release action and release_pulse at edge N.

Test Plan (LONG_LIMIT=8, BLINK_HALF=4):
- Reset, hold sw_db=0 for 10 cycles -> led=0, release_pulse=0, long_press=0, blink_mode=0 throughout.
- sw_db high for 3 edges, then low -> release_pulse high for exactly 1 cycle, led 0->1. Repeat the same press -> led 1->0.
- Boundary: press sampled high on 7 edges -> short release, led toggles, long_press never pulses. Press sampled high on 8 edges -> long_press pulses on the 8th edge.
- Long press (12 edges) from led_state=0, then release -> blink_mode=1 and led=1 immediately after the release edge. led then toggles every 4 cycles (1,1,1,1,0,0,0,0,...).
- In BLINK, 2-edge short press then release -> blink_mode=0, led=0 (the saved led_state). Repeat the long press then a long release -> BLINK entered, then left again, with led_state preserved.
- Assert rst_n low mid-press (press_cnt=5) and during BLINK -> all outputs read 0 immediately (asynchronously). After release of reset with sw_db=1, the first edge is treated as press_start.

Source files
------------

// File: rtl/sw_release_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sw_release_led_ctrl
// Description : Drives the board LED from a debounced switch level. A short
//               press followed by release toggles the steady LED state. A
//               long press followed by release toggles between steady and
//               blink display modes.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_release_led_ctrl #(
    parameter int LONG_LIMIT = 25000000,
    parameter int BLINK_HALF = 6250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_db,
    output logic led,
    output logic release_pulse,
    output logic long_press,
    output logic blink_mode
);

    localparam int c_press_w = $clog2(LONG_LIMIT + 1);
    localparam int c_blink_w = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [c_press_w-1:0] c_press_one  = c_press_w'(1);
    localparam logic [c_press_w-1:0] c_press_max  = c_press_w'(LONG_LIMIT);
    localparam logic [c_press_w-1:0] c_press_last = c_press_w'(LONG_LIMIT - 1);
    localparam logic [c_blink_w-1:0] c_blink_one  = c_blink_w'(1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_HALF - 1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_pressed = 2'd1;
    localparam logic [1:0] c_st_long    = 2'd2;

    localparam logic c_mode_steady = 1'b0;
    localparam logic c_mode_blink  = 1'b1;

    logic                 r_sw_d;
    logic [c_press_w-1:0] r_press_cnt;
    logic [1:0]           r_state;
    logic                 r_mode;
    logic                 r_led_state;
    logic                 r_blink_phase;
    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_release_pulse;
    logic                 r_long_press;

    logic       w_press_start;
    logic       w_release;
    logic [1:0] w_state_nxt;
    logic       w_long_hit;
    logic       w_short_rel;
    logic       w_long_rel;

    assign w_press_start = sw_db & ~r_sw_d;
    assign w_release     = ~sw_db & r_sw_d;

    // Previous-edge copy of the switch level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sw_d <= 1'b0;
        else        r_sw_d <= sw_db;
    end

    // Press duration counter; restarts at 1 on a new press and saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_press_cnt <= '0;
        end else if (w_press_start) begin
            r_press_cnt <= c_press_one;
        end else if (sw_db && (r_press_cnt != c_press_max)) begin
            r_press_cnt <= r_press_cnt + c_press_one;
        end
    end

    // Press classification state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    // Next state and release/long-press classification strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_long_hit  = 1'b0;
        w_short_rel = 1'b0;
        w_long_rel  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_press_start) w_state_nxt = c_st_pressed;
            end
            c_st_pressed: begin
                if (w_release) begin
                    w_short_rel = 1'b1;
                    w_state_nxt = c_st_idle;
                end else if (sw_db && (r_press_cnt == c_press_last)) begin
                    // This edge brings the count to LONG_LIMIT.
                    w_long_hit  = 1'b1;
                    w_state_nxt = c_st_long;
                end
            end
            c_st_long: begin
                if (w_release) begin
                    w_long_rel  = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // One-cycle event pulses, registered so outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_release_pulse <= 1'b0;
            r_long_press    <= 1'b0;
        end else begin
            r_release_pulse <= w_release;
            r_long_press    <= w_long_hit;
        end
    end

    // Display mode, steady LED state and blink generator; release actions
    // take priority over the free-running blink timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode        <= c_mode_steady;
            r_led_state   <= 1'b0;
            r_blink_phase <= 1'b0;
            r_blink_cnt   <= '0;
        end else if (w_short_rel) begin
            if (r_mode == c_mode_steady) r_led_state <= ~r_led_state;
            else                         r_mode      <= c_mode_steady;
            r_blink_cnt <= '0;
        end else if (w_long_rel) begin
            if (r_mode == c_mode_steady) begin
                r_mode        <= c_mode_blink;
                // Start blinking in the opposite phase so the change is visible.
                r_blink_phase <= ~r_led_state;
            end else begin
                r_mode <= c_mode_steady;
            end
            r_blink_cnt <= '0;
        end else if (r_mode == c_mode_blink) begin
            if (r_blink_cnt == c_blink_last) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + c_blink_one;
            end
        end else begin
            r_blink_cnt <= '0;
        end
    end

    assign blink_mode    = (r_mode == c_mode_blink);
    assign led           = blink_mode ? r_blink_phase : r_led_state;
    assign release_pulse = r_release_pulse;
    assign long_press    = r_long_press;

endmodule
`default_nettype wire
